// File: rtl/cpu_pkg.sv
// Shared constants and loader state type for the CPU boot memory slice.
package cpu_pkg;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,
        LOAD_LO = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } load_state_e;

endpackage

// File: rtl/cpu_ram_1k16.sv
// 1K x 16 unified memory: loader write on the rising edge, CPU write taken on
// the falling edge, combinational read.
module cpu_ram_1k16
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // The CPU write is captured on the falling edge and folded into the
    // array on the next rising edge, so the array has a single write clock;
    // the read bypass makes the captured word visible from the falling edge.
    logic              pend_we;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;

    // Falling-edge capture of the CPU write port.
    always_ff @(negedge clk) begin
        pend_we   <= cpu_we;
        pend_addr <= cpu_addr;
        pend_data <= cpu_wdata;
    end

    // Array update: loader and CPU writes are mutually exclusive by gating.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_wdata;
        end else if (pend_we) begin
            mem[pend_addr] <= pend_data;
        end
    end

    // Zero-latency read with bypass of the just-captured CPU write.
    always_comb begin
        rd_data = mem[rd_addr];
        if (pend_we && (pend_addr == rd_addr)) begin
            rd_data = pend_data;
        end
    end

endmodule

// File: rtl/cpu_boot_memory.sv
// CPU program/data memory with a byte-serial boot loader that holds the CPU
// in reset until the image is in place.
// Optional: define CPU_BOOT_CHECKSUM_EN to add the load_checksum output.
module cpu_boot_memory
    import cpu_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [BYTE_W-1:0] load_byte,
    input  logic              load_last,
    output logic              cpu_reset,
    output logic              boot_done,
    output logic [CNT_W-1:0]  word_count,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] memory_address,
    input  logic [DATA_W-1:0] memory_out,
    output logic [DATA_W-1:0] memory_in
`ifdef CPU_BOOT_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] load_checksum
`endif
);

    localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  word_count_d;
    logic              cpu_reset_d;
    logic              boot_done_d;
    logic              load_ready_d;

    logic              accept_c;
    logic              ld_we_c;
    logic [DATA_W-1:0] ld_wdata_c;
    logic              cpu_we_c;

    assign accept_c = load_valid && load_ready;
    assign cpu_we_c = read_write && !cpu_reset;

    // State and loader registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOAD_HI;
            addr_q     <= '0;
            hi_q       <= '0;
            hold_q     <= '0;
            word_count <= '0;
            cpu_reset  <= 1'b1;
            boot_done  <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            hold_q     <= hold_d;
            word_count <= word_count_d;
            cpu_reset  <= cpu_reset_d;
            boot_done  <= boot_done_d;
            load_ready <= load_ready_d;
        end
    end

    // Loader next-state, word assembly and release sequencing.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        hi_d         = hi_q;
        hold_d       = hold_q;
        word_count_d = word_count;
        cpu_reset_d  = cpu_reset;
        boot_done_d  = boot_done;
        ld_we_c      = 1'b0;
        ld_wdata_c   = {hi_q, load_byte};

        case (state_q)
            LOAD_HI: begin
                if (accept_c) begin
                    hi_d = load_byte;
                    if (load_last) begin
                        ld_we_c      = 1'b1;
                        ld_wdata_c   = {load_byte, BYTE_W'(0)};
                        word_count_d = word_count + CNT_W'(1);
                        state_d      = RELEASE;
                    end else begin
                        state_d = LOAD_LO;
                    end
                end
            end
            LOAD_LO: begin
                if (accept_c) begin
                    ld_we_c      = 1'b1;
                    ld_wdata_c   = {hi_q, load_byte};
                    addr_d       = addr_q + ADDR_W'(1);
                    word_count_d = word_count + CNT_W'(1);
                    if (load_last || (addr_q == ADDR_W'(MEM_DEPTH - 1))) begin
                        state_d = RELEASE;
                    end else begin
                        state_d = LOAD_HI;
                    end
                end
            end
            RELEASE: begin
                if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
                    cpu_reset_d = 1'b0;
                    boot_done_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            DONE: begin
            end
            default: begin
                state_d = LOAD_HI;
            end
        endcase

        load_ready_d = (state_d == LOAD_HI) || (state_d == LOAD_LO);
    end

`ifdef CPU_BOOT_CHECKSUM_EN
    // Running sum of every word the loader writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_checksum <= '0;
        end else if (ld_we_c) begin
            load_checksum <= load_checksum + ld_wdata_c;
        end
    end
`endif

    cpu_ram_1k16 u_ram (
        .clk       (clk),
        .ld_we     (ld_we_c),
        .ld_addr   (addr_q),
        .ld_wdata  (ld_wdata_c),
        .cpu_we    (cpu_we_c),
        .cpu_addr  (memory_address),
        .cpu_wdata (memory_out),
        .rd_addr   (memory_address),
        .rd_data   (memory_in)
    );

endmodule
